// File: rtl/vga_image_scanner.sv
// vga_image_scanner: 640x480@60 VGA timing generator that raster-scans a
// centred grayscale image out of VRAM and presents it as aligned RGB/sync.
module vga_image_scanner #(
    parameter int unsigned IMG_W = 300,
    parameter int unsigned IMG_H = 300,
    parameter int unsigned X_OFF = 170,
    parameter int unsigned Y_OFF = 90
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  vram_out,
    output logic [31:0] gpu_address,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL    = 800;
    localparam int unsigned H_VISIBLE  = 640;
    localparam int unsigned H_SYNC_BEG = 656;
    localparam int unsigned H_SYNC_END = 752;
    localparam int unsigned V_TOTAL    = 525;
    localparam int unsigned V_VISIBLE  = 480;
    localparam int unsigned V_SYNC_BEG = 490;
    localparam int unsigned V_SYNC_END = 492;
    localparam int unsigned CNT_W      = 10;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned PIX_W      = 8;
    localparam int unsigned PIX_COUNT  = IMG_W * IMG_H;

    // Per-position timing flags carried alongside the pixel data.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank_n;
        logic in_win;
        logic first;
    } scan_flags_t;

    localparam scan_flags_t FLAGS_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0,
                                           in_win: 1'b0, first: 1'b0};

    logic [CNT_W-1:0]  h;
    logic [CNT_W-1:0]  v;
    logic [ADDR_W-1:0] addr;
    logic              h_wrap_c;
    logic              v_wrap_c;
    logic              in_win_c;
    logic              addr_last_c;
    scan_flags_t       flags_c;
    scan_flags_t       flags_q;

    // Decode the current counter position into wrap, window and sync flags.
    always_comb begin
        h_wrap_c      = (h == CNT_W'(H_TOTAL - 1));
        v_wrap_c      = (v == CNT_W'(V_TOTAL - 1));
        in_win_c      = (h >= CNT_W'(X_OFF)) && (h < CNT_W'(X_OFF + IMG_W)) &&
                        (v >= CNT_W'(Y_OFF)) && (v < CNT_W'(Y_OFF + IMG_H));
        addr_last_c   = (addr == ADDR_W'(PIX_COUNT - 1));
        flags_c.hsync   = !((h >= CNT_W'(H_SYNC_BEG)) && (h < CNT_W'(H_SYNC_END)));
        flags_c.vsync   = !((v >= CNT_W'(V_SYNC_BEG)) && (v < CNT_W'(V_SYNC_END)));
        flags_c.blank_n = (h < CNT_W'(H_VISIBLE)) && (v < CNT_W'(V_VISIBLE));
        flags_c.in_win  = in_win_c;
        flags_c.first   = (h == '0) && (v == '0);
    end

    // Horizontal/vertical position counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h <= '0;
            v <= '0;
        end else if (h_wrap_c) begin
            h <= '0;
            v <= v_wrap_c ? '0 : v + CNT_W'(1);
        end else begin
            h <= h + CNT_W'(1);
        end
    end

    // Raster address: steps through the window, frame wrap wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr <= '0;
        end else if (h_wrap_c && v_wrap_c) begin
            addr <= '0;
        end else if (in_win_c) begin
            addr <= addr_last_c ? '0 : addr + ADDR_W'(1);
        end
    end

    assign gpu_address = addr;

    // Two-stage delay so sync/blank line up with the VRAM read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q     <= FLAGS_IDLE;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_n     <= 1'b0;
            frame_start <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
        end else begin
            flags_q     <= flags_c;
            hsync       <= flags_q.hsync;
            vsync       <= flags_q.vsync;
            blank_n     <= flags_q.blank_n;
            frame_start <= flags_q.first;
            r           <= flags_q.in_win ? vram_out : PIX_W'(0);
            g           <= flags_q.in_win ? vram_out : PIX_W'(0);
            b           <= flags_q.in_win ? vram_out : PIX_W'(0);
        end
    end

endmodule

// File: doc/vga_image_scanner.md
# vga_image_scanner

Display-side consumer of the processor's VRAM read port. Generates 640x480@60 Hz VGA timing from a 25 MHz pixel clock, drives `gpu_address` to scan the 300x300 8-bit grayscale result image in raster order, and turns the returned `vram_out` bytes into aligned RGB/sync outputs. The image is centred in the visible area; everything outside the image window is black.

## Interface
- IMG_W, 300, image width in pixels
- IMG_H, 300, image height in pixels
- X_OFF, 170, first visible column of the image window
- Y_OFF, 90, first visible line of the image window
- clk  in  1  pixel clock, 25 MHz; all logic on rising edge
- reset  in  1  asynchronous, active-low (asserted when 0)
- vram_out  in  8  pixel byte; valid the cycle after `gpu_address` is presented
- gpu_address  out  32  VRAM read address, 0..IMG_W*IMG_H-1
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- blank_n  out  1  1 inside the 640x480 visible area
- r, g, b  out  8 each  pixel colour; all three equal `vram_out` inside window
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

## Operation
- Horizontal counter `h` 0..799: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical counter `v` 0..524, advances when `h` wraps 799->0: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- In-window: X_OFF <= h < X_OFF+IMG_W and Y_OFF <= v < Y_OFF+IMG_H (h 170..469, v 90..389 at defaults).
- Address counter `addr`, drives `gpu_address` directly (registered, no multiplier):
  - increments by 1 at the end of every in-window cycle; holds otherwise;
  - after IMG_W*IMG_H-1 (89999) it wraps to 0;
  - forced to 0 when counters wrap (h=799, v=524 -> 0,0), so every frame restarts at 0 regardless of history.
- Pixel for counter position (h,v) therefore has address (v-Y_OFF)*IMG_W + (h-X_OFF).
- Output stage: sync, blank and in-window flags computed from (h,v) are delayed through 2 pipeline registers; r/g/b register `vram_out` when the once-delayed in-window flag is 1, else 0.
- Outside visible area r/g/b = 0 and blank_n = 0; inside visible but outside window r/g/b = 0, blank_n = 1.

## Timing
- Reset (reset=0, async): h=0, v=0, gpu_address=0, hsync=1, vsync=1, blank_n=0, r=g=b=0, frame_start=0; all pipeline registers cleared. Reset mid-frame aborts the scan; first cycle after release is counter position (0,0).
- Latency: counters at (h,v) in cycle t -> `gpu_address` valid in t -> `vram_out` sampled at end of t+1 -> r/g/b, hsync, vsync, blank_n, frame_start for (h,v) visible in cycle t+2. Sync/blank share exactly the 2-cycle delay with pixel data.
- frame_start high for exactly one cycle, 2 cycles after counters reach (0,0); period 420000 cycles.
- hsync low for 96 consecutive cycles per line; vsync low for 2 lines (1600 cycles) per frame.
- Line/frame wrap and window exit in the same cycle: wrap-to-0 of `addr` takes priority over increment.
- No back-pressure; `vram_out` is sampled unconditionally.

## Test plan
- Reset: hold reset=0 for 3 cycles mid-frame -> all outputs at reset values during reset; after release hsync falls 656+2 cycles later, frame_start pulses at cycle 2.
- Sync timing: run 2 frames -> hsync period 800, low width 96; vsync period 420000, low width 1600; blank_n high 640 cycles per visible line, 480 lines.
- Address sweep: model VRAM with data = address[7:0] -> gpu_address 0 at (170,90), 299 at (469,90), 300 at (170,91), 89999 at (469,389); exactly 90000 increments per frame.
- Alignment: model returns 8'hFF at address 0, 8'h00 elsewhere -> single white pixel on output cycle exactly 2 after counters hit (170,90); r=g=b=FF, blank_n=1.
- Border: VRAM returns 8'hAA everywhere -> r/g/b=AA only in window, 0 at h=169/470 and v=89/390 positions.
- Frame restart: assert reset mid-image (addr≈45000), release -> next frame's first window pixel reads address 0.
